// File: rtl/hazard_scoreboard_if.sv
// Hazard-unit interface: ID/EX/MEM/WB pipeline state in; stall, forward and
// scoreboard status out.
interface hazard_scoreboard_if #(
    parameter int AW   = 5,
    parameter int NENT = 2,
    parameter int LW   = 4,
    parameter int CW   = 32
);
    logic            BranchD;
    logic            JumpR;
    logic            MdOpD;
    logic            RegWriteD;
    logic [AW-1:0]   RsD;
    logic [AW-1:0]   RtD;
    logic [AW-1:0]   WriteRegD;
    logic [AW-1:0]   RsE;
    logic [AW-1:0]   RtE;
    logic [AW-1:0]   WriteRegE;
    logic            MemtoRegE;
    logic            RegWriteE;
    logic            MdIssueE;
    logic [LW-1:0]   MdLatE;
    logic [AW-1:0]   WriteRegM;
    logic [AW-1:0]   WriteRegW;
    logic            MemtoRegM;
    logic            RegWriteM;
    logic            RegWriteW;
    logic            ClrCnt;
    logic            StallF;
    logic            StallD;
    logic            FlushE;
    logic            ForwardAD;
    logic            ForwardBD;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [NENT-1:0] MdBusy;
    logic            MdFull;
    logic [CW-1:0]   StallCount;

    modport master (
        output BranchD, JumpR, MdOpD, RegWriteD, RsD, RtD, WriteRegD,
               RsE, RtE, WriteRegE, MemtoRegE, RegWriteE, MdIssueE, MdLatE,
               WriteRegM, WriteRegW, MemtoRegM, RegWriteM, RegWriteW, ClrCnt,
        input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE,
               ForwardBE, MdBusy, MdFull, StallCount
    );

    modport slave (
        input  BranchD, JumpR, MdOpD, RegWriteD, RsD, RtD, WriteRegD,
               RsE, RtE, WriteRegE, MemtoRegE, RegWriteE, MdIssueE, MdLatE,
               WriteRegM, WriteRegW, MemtoRegM, RegWriteM, RegWriteW, ClrCnt,
        output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE,
               ForwardBE, MdBusy, MdFull, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// MIPS 5-stage hazard unit: classic forwarding/load-use/branch stalls plus a
// scoreboard of outstanding multi-cycle ops with latency countdown.
module hazard_scoreboard #(
    parameter int AW   = 5,
    parameter int NENT = 2,
    parameter int LW   = 4,
    parameter int CW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave bus
);
    logic [NENT-1:0][AW-1:0] dst_q, dst_d;
    logic [NENT-1:0][LW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]           stall_cnt_q, stall_cnt_d;
    logic [NENT-1:0]         busy;
    logic [NENT-1:0]         live;
    logic                    lw_stall, br_stall, raw_stall, waw_stall, struct_stall;
    logic                    stall;
    logic                    issue;
    logic                    alloc_done;
    logic [LW-1:0]           issue_lat;
    logic [AW-1:0]           issue_dst;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                           input logic [AW-1:0] wr_m, input logic we_m,
                                           input logic [AW-1:0] wr_w, input logic we_w);
        if (src != '0 && src == wr_m && we_m) return 2'd2;
        if (src != '0 && src == wr_w && we_w) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic dst_hit(input logic [AW-1:0] wr,
                                     input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (wr != '0) && (wr == a || wr == b);
    endfunction

    always_comb begin
        bus.ForwardAE = fwd_sel(bus.RsE, bus.WriteRegM, bus.RegWriteM, bus.WriteRegW, bus.RegWriteW);
        bus.ForwardBE = fwd_sel(bus.RtE, bus.WriteRegM, bus.RegWriteM, bus.WriteRegW, bus.RegWriteW);
        bus.ForwardAD = (bus.RsD != '0) && (bus.RsD == bus.WriteRegM) && bus.RegWriteM;
        bus.ForwardBD = (bus.RtD != '0) && (bus.RtD == bus.WriteRegM) && bus.RegWriteM;
    end

    always_comb begin
        lw_stall = bus.MemtoRegE && (bus.RtE != '0) &&
                   (bus.RsD == bus.RtE || bus.RtD == bus.RtE);
        br_stall = (bus.BranchD || bus.JumpR) &&
                   ((bus.RegWriteE && dst_hit(bus.WriteRegE, bus.RsD, bus.RtD)) ||
                    (bus.MemtoRegM && dst_hit(bus.WriteRegM, bus.RsD, bus.RtD)));
    end

    // Entries with dst==0 (suppressed issues) are timed but never match.
    always_comb begin
        busy      = '0;
        live      = '0;
        raw_stall = 1'b0;
        waw_stall = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            busy[i] = (cnt_q[i] != '0);
            live[i] = busy[i] && (dst_q[i] != '0);
            if (live[i] && (dst_q[i] == bus.RsD || dst_q[i] == bus.RtD))
                raw_stall = 1'b1;
            if (live[i] && bus.RegWriteD && (bus.WriteRegD == dst_q[i]))
                waw_stall = 1'b1;
        end
        struct_stall = bus.MdOpD && ((&busy) || (bus.MdIssueE && $onehot(~busy)));
        stall        = lw_stall || br_stall || raw_stall || waw_stall || struct_stall;
    end

    always_comb begin
        bus.StallF     = stall;
        bus.StallD     = stall;
        bus.FlushE     = stall;
        bus.MdBusy     = busy;
        bus.MdFull     = &busy;
        bus.StallCount = stall_cnt_q;
    end

    // Allocation looks only at pre-edge idle entries, so a retiring entry
    // is not reusable until the following cycle.
    always_comb begin
        issue      = bus.MdIssueE && !stall;
        issue_lat  = (bus.MdLatE == '0) ? LW'(1) : bus.MdLatE;
        issue_dst  = (bus.RegWriteE && bus.WriteRegE != '0) ? bus.WriteRegE : '0;
        cnt_d      = cnt_q;
        dst_d      = dst_q;
        alloc_done = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - LW'(1);
        end
        if (issue) begin
            for (int i = 0; i < NENT; i++) begin
                if (!alloc_done && cnt_q[i] == '0) begin
                    alloc_done = 1'b1;
                    cnt_d[i]   = issue_lat;
                    dst_d[i]   = issue_dst;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.ClrCnt)
            stall_cnt_d = '0;
        else if (stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dst_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            dst_q       <= dst_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random traffic, all
// compared against a list-of-outstanding-ops reference model.
module tb_hazard_scoreboard;
    localparam int AW   = 5;
    localparam int NENT = 2;
    localparam int LW   = 4;
    localparam int CW   = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    int     m_rem [NENT];
    int     m_dst [NENT];
    longint m_cnt;

    hazard_scoreboard_if #(.AW(AW), .NENT(NENT), .LW(LW), .CW(CW)) bus ();
    hazard_scoreboard_if #(.AW(AW), .NENT(NENT), .LW(LW), .CW(4))  sbus ();

    hazard_scoreboard #(.AW(AW), .NENT(NENT), .LW(LW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    hazard_scoreboard #(.AW(AW), .NENT(NENT), .LW(LW), .CW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        bus.BranchD = 0; bus.JumpR = 0; bus.MdOpD = 0; bus.RegWriteD = 0;
        bus.RsD = 0; bus.RtD = 0; bus.WriteRegD = 0;
        bus.RsE = 0; bus.RtE = 0; bus.WriteRegE = 0;
        bus.MemtoRegE = 0; bus.RegWriteE = 0; bus.MdIssueE = 0; bus.MdLatE = 0;
        bus.WriteRegM = 0; bus.WriteRegW = 0;
        bus.MemtoRegM = 0; bus.RegWriteM = 0; bus.RegWriteW = 0; bus.ClrCnt = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin m_rem[i] = 0; m_dst[i] = 0; end
        m_cnt = 0;
    endtask

    function automatic int fwd_e(input int src);
        if (src != 0 && src == int'(bus.WriteRegM) && bus.RegWriteM) return 2;
        if (src != 0 && src == int'(bus.WriteRegW) && bus.RegWriteW) return 1;
        return 0;
    endfunction

    function automatic int free_slots();
        int n = 0;
        for (int i = 0; i < NENT; i++) if (m_rem[i] == 0) n++;
        return n;
    endfunction

    function automatic bit m_stall();
        int rs  = int'(bus.RsD);
        int rt  = int'(bus.RtD);
        int wd  = int'(bus.WriteRegD);
        int rte = int'(bus.RtE);
        int wre = int'(bus.WriteRegE);
        int wrm = int'(bus.WriteRegM);
        bit lw, br, raw, waw, st;
        lw  = bus.MemtoRegE && rte != 0 && (rs == rte || rt == rte);
        br  = (bus.BranchD || bus.JumpR) &&
              ((bus.RegWriteE && wre != 0 && (wre == rs || wre == rt)) ||
               (bus.MemtoRegM && wrm != 0 && (wrm == rs || wrm == rt)));
        raw = 0; waw = 0;
        for (int i = 0; i < NENT; i++) begin
            if (m_rem[i] > 0 && m_dst[i] != 0) begin
                if (m_dst[i] == rs || m_dst[i] == rt) raw = 1;
                if (bus.RegWriteD && m_dst[i] == wd) waw = 1;
            end
        end
        st = bus.MdOpD && (free_slots() == 0 || (bus.MdIssueE && free_slots() == 1));
        return lw || br || raw || waw || st;
    endfunction

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic cycle();
        bit s;
        int slot;
        logic [NENT-1:0] eb;
        @(negedge clk);
        s = m_stall();
        eb = '0;
        for (int i = 0; i < NENT; i++) eb[i] = (m_rem[i] > 0);
        chk("ForwardAE", 64'(bus.ForwardAE), 64'(fwd_e(int'(bus.RsE))));
        chk("ForwardBE", 64'(bus.ForwardBE), 64'(fwd_e(int'(bus.RtE))));
        chk("ForwardAD", 64'(bus.ForwardAD),
            64'(bus.RsD != 0 && bus.RsD == bus.WriteRegM && bus.RegWriteM));
        chk("ForwardBD", 64'(bus.ForwardBD),
            64'(bus.RtD != 0 && bus.RtD == bus.WriteRegM && bus.RegWriteM));
        chk("StallF", 64'(bus.StallF), 64'(s));
        chk("StallD", 64'(bus.StallD), 64'(s));
        chk("FlushE", 64'(bus.FlushE), 64'(s));
        chk("MdBusy", 64'(bus.MdBusy), 64'(eb));
        chk("MdFull", 64'(bus.MdFull), 64'(free_slots() == 0));
        chk("StallCount", 64'(bus.StallCount), 64'(m_cnt));
        chk("no_issue_when_full", 64'(bus.MdIssueE && bus.MdFull), 64'd0);
        @(posedge clk);
        slot = -1;
        if (bus.MdIssueE && !s) begin
            for (int i = 0; i < NENT; i++)
                if (slot < 0 && m_rem[i] == 0) slot = i;
        end
        for (int i = 0; i < NENT; i++)
            if (i != slot && m_rem[i] > 0) m_rem[i]--;
        if (slot >= 0) begin
            m_rem[slot] = (bus.MdLatE == 0) ? 1 : int'(bus.MdLatE);
            m_dst[slot] = (bus.RegWriteE && bus.WriteRegE != 0) ? int'(bus.WriteRegE) : 0;
        end
        if (bus.ClrCnt) m_cnt = 0;
        else if (s && m_cnt != 64'hFFFF_FFFF) m_cnt++;
        #1;
    endtask

    task automatic clear_count();
        bus.ClrCnt = 1; cycle(); bus.ClrCnt = 0;
    endtask

    task automatic issue(input int dst, input int lat);
        bus.MdIssueE = 1; bus.RegWriteE = 1; bus.WriteRegE = AW'(dst); bus.MdLatE = LW'(lat);
        cycle();
        bus.MdIssueE = 0; bus.RegWriteE = 0; bus.WriteRegE = 0; bus.MdLatE = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        clr_in();
        sbus.BranchD = 0; sbus.JumpR = 0; sbus.MdOpD = 0; sbus.RegWriteD = 0;
        sbus.RsD = 0; sbus.RtD = 0; sbus.WriteRegD = 0;
        sbus.RsE = 0; sbus.RtE = 0; sbus.WriteRegE = 0;
        sbus.MemtoRegE = 0; sbus.RegWriteE = 0; sbus.MdIssueE = 0; sbus.MdLatE = 0;
        sbus.WriteRegM = 0; sbus.WriteRegW = 0;
        sbus.MemtoRegM = 0; sbus.RegWriteM = 0; sbus.RegWriteW = 0; sbus.ClrCnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_MdBusy", 64'(bus.MdBusy), 64'd0);
        chk("reset_StallCount", 64'(bus.StallCount), 64'd0);
        chk("reset_StallD", 64'(bus.StallD), 64'd0);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // Forwarding priority
        bus.RsE = 5; bus.RtE = 5;
        bus.WriteRegM = 5; bus.RegWriteM = 1; bus.WriteRegW = 5; bus.RegWriteW = 1;
        cycle();
        chk("fwd_mem_A", 64'(bus.ForwardAE), 64'd2);
        chk("fwd_mem_B", 64'(bus.ForwardBE), 64'd2);
        bus.RegWriteM = 0;
        cycle();
        chk("fwd_wb_A", 64'(bus.ForwardAE), 64'd1);
        chk("fwd_wb_B", 64'(bus.ForwardBE), 64'd1);
        bus.RsE = 0;
        cycle();
        chk("fwd_r0_A", 64'(bus.ForwardAE), 64'd0);
        clr_in();

        // Load-use
        clear_count();
        bus.MemtoRegE = 1; bus.RtE = 8; bus.RsD = 8;
        #1 chk("lw_stall", 64'(bus.StallD), 64'd1);
        cycle();
        chk("lw_count", 64'(bus.StallCount), 64'd1);
        bus.RtE = 0;
        #1 chk("lw_r0_nostall", 64'(bus.StallF), 64'd0);
        cycle();
        chk("lw_r0_count", 64'(bus.StallCount), 64'd1);
        clr_in();

        // Multi-cycle RAW
        clear_count();
        issue(9, 3);
        bus.RsD = 9;
        repeat (3) cycle();
        chk("raw_release", 64'(bus.StallD), 64'd0);
        chk("raw_count", 64'(bus.StallCount), 64'd3);
        clr_in();

        // Structural
        clear_count();
        issue(10, 4);
        issue(11, 4);
        bus.MdOpD = 1;
        #1 chk("struct_full", 64'(bus.MdFull), 64'd1);
        chk("struct_stall", 64'(bus.StallD), 64'd1);
        repeat (3) cycle();
        chk("struct_busy", 64'(bus.MdBusy), 64'b10);
        chk("struct_release", 64'(bus.StallD), 64'd0);
        chk("struct_count", 64'(bus.StallCount), 64'd3);
        clr_in();
        cycle();

        // Retire and issue on the same edge
        issue(12, 2);
        cycle();
        issue(13, 3);
        chk("retire_issue_busy", 64'(bus.MdBusy), 64'b10);
        repeat (3) cycle();
        chk("retire_issue_idle", 64'(bus.MdBusy), 64'b00);

        // Asynchronous reset mid-op
        issue(14, 7);
        bus.RsD = 14;
        repeat (2) cycle();
        #2 rst_n = 0;
        #1;
        chk("rst_mid_busy", 64'(bus.MdBusy), 64'd0);
        chk("rst_mid_count", 64'(bus.StallCount), 64'd0);
        chk("rst_mid_stall", 64'(bus.StallD), 64'd0);
        model_reset();
        clr_in();
        @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.RsD = AW'($urandom_range(0, 7)); bus.RtD = AW'($urandom_range(0, 7));
            bus.WriteRegD = AW'($urandom_range(0, 7));
            bus.RsE = AW'($urandom_range(0, 7)); bus.RtE = AW'($urandom_range(0, 7));
            bus.WriteRegE = AW'($urandom_range(0, 7));
            bus.WriteRegM = AW'($urandom_range(0, 7)); bus.WriteRegW = AW'($urandom_range(0, 7));
            bus.BranchD   = ($urandom_range(0, 7) == 0);
            bus.JumpR     = ($urandom_range(0, 7) == 0);
            bus.MdOpD     = ($urandom_range(0, 3) == 0);
            bus.RegWriteD = ($urandom_range(0, 1) == 0);
            bus.MemtoRegE = ($urandom_range(0, 3) == 0);
            bus.RegWriteE = ($urandom_range(0, 3) != 0);
            bus.MemtoRegM = ($urandom_range(0, 3) == 0);
            bus.RegWriteM = ($urandom_range(0, 1) == 0);
            bus.RegWriteW = ($urandom_range(0, 1) == 0);
            bus.ClrCnt    = ($urandom_range(0, 31) == 0);
            bus.MdLatE    = LW'($urandom_range(0, 6));
            bus.MdIssueE  = (free_slots() > 0) && ($urandom_range(0, 2) == 0);
            cycle();
        end
        clr_in();

        // Saturation on the 4-bit counter instance
        sbus.MemtoRegE = 1; sbus.RtE = 3; sbus.RsD = 3;
        repeat (14) @(posedge clk);
        #1 chk("sat_count14", 64'(sbus.StallCount), 64'd14);
        repeat (6) @(posedge clk);
        #1 chk("sat_hold15", 64'(sbus.StallCount), 64'd15);
        sbus.ClrCnt = 1;
        @(posedge clk);
        #1 chk("sat_clr_priority", 64'(sbus.StallCount), 64'd0);
        sbus.ClrCnt = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline.
- Keeps the existing single-cycle logic: EX/ID forwarding selects, load-use stall, and branch/jr-in-ID stall.
- Adds a registered scoreboard of NENT outstanding multi-cycle (mul/div) operations, each with a per-entry latency countdown. It stalls ID on RAW, WAW and structural hazards against those operations and keeps a saturating stall-cycle counter.

Parameters:
- AW, 5, register address width.
- NENT, 2, number of multi-cycle operations that may be outstanding at once (1..8).
- LW, 4, latency counter width; maximum latency is 2^LW-1.
- CW, 32, stall performance counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- BranchD  in  1  branch in ID.
- JumpR  in  1  jr/jalr in ID.
- MdOpD  in  1  ID instruction is a multi-cycle op.
- RegWriteD  in  1  ID instruction writes a GPR.
- RsD, RtD, WriteRegD  in  AW each  ID sources and destination.
- RsE, RtE, WriteRegE  in  AW each  EX sources and destination.
- MemtoRegE, RegWriteE  in  1 each  EX control.
- MdIssueE  in  1  multi-cycle op valid in EX this cycle.
- MdLatE  in  LW  latency of the issuing op, in cycles.
- WriteRegM, WriteRegW  in  AW each  MEM/WB destinations.
- MemtoRegM, RegWriteM, RegWriteW  in  1 each  MEM/WB control.
- ClrCnt  in  1  synchronous clear of StallCount.
- StallF, StallD, FlushE  out  1 each  pipeline control.
- ForwardAD, ForwardBD  out  1 each  forward MEM result to the ID comparator.
- ForwardAE, ForwardBE  out  2 each  EX operand select: 0 = register file, 1 = WB, 2 = MEM.
- MdBusy  out  NENT  per-entry busy flags.
- MdFull  out  1  all entries busy.
- StallCount  out  CW  saturating count of stalled cycles.

Behaviour:
- Forwarding, combinational:
  - ForwardAE = 2 if RsE!=0 & RsE==WriteRegM & RegWriteM.
  - Else ForwardAE = 1 if RsE!=0 & RsE==WriteRegW & RegWriteW.
  - Else ForwardAE = 0.
  - ForwardBE follows the same rules using RtE.
  - ForwardAD = RsD!=0 & RsD==WriteRegM & RegWriteM. ForwardBD follows the same rule using RtD.
- Lwstall = MemtoRegE & RtE!=0 & (RsD==RtE | RtD==RtE).
- BrStall:
  - Qualified by (BranchD|JumpR).
  - Fires when RegWriteE & WriteRegE!=0 & WriteRegE matches RsD or RtD.
  - Also fires when MemtoRegM & WriteRegM!=0 & WriteRegM matches RsD or RtD.
  - A register number of 0 never matches in either term.
- Scoreboard:
  - Each entry i holds dst[i] (AW bits) and cnt[i] (LW bits). busy[i] = (cnt[i]!=0).
  - Issue: on a rising edge with MdIssueE=1 and FlushE=0, the lowest-index non-busy entry loads dst<=WriteRegE and cnt<=max(MdLatE,1).
  - Issue is suppressed when WriteRegE==0 or RegWriteE==0. In that case the op is still timed: it occupies an entry with the same latency, but that entry never matches as RAW/WAW.
  - Countdown: every edge, each busy entry not being loaded decrements by 1. An entry decrementing from 1 to 0 retires; the datapath guarantees its result is in the register file or on the WB forward path in the following cycle.
  - Simultaneous retire and issue on the same edge: the issue allocates only among entries that were non-busy before the edge. A retiring entry becomes allocatable one cycle later.
  - MdIssueE with MdFull=1 is a protocol violation, prevented by StructStall. The bench asserts it never occurs.
- ID hazard terms against busy entries with a nonzero dst:
  - RawStall: RsD or RtD equals dst[i].
  - WawStall: RegWriteD & WriteRegD==dst[i].
  - StructStall: MdOpD & (MdFull | (MdIssueE & exactly one free entry)).
- Stall combination:
  - Stall = Lwstall|BrStall|RawStall|WawStall|StructStall.
  - StallF = StallD = FlushE = Stall.
- MdBusy = busy vector. MdFull = &busy.
- StallCount:
  - Increments on every edge where Stall=1.
  - Saturates at all-ones.
  - ClrCnt has priority over increment and forces 0.
- Reset, asynchronous with rst_n low: all cnt=0, all dst=0, StallCount=0.
  - Consequently MdBusy=0, MdFull=0, and Stall is driven only by the combinational terms.
  - Reset during an outstanding op abandons it without retiring it.
- Only Stall-free cycles advance ID. Stall affects neither the countdown nor forwarding.

Test Plan:
- Forwarding: RsE=RtE=5, WriteRegM=5 & RegWriteM, WriteRegW=5 & RegWriteW -> ForwardAE=ForwardBE=2. Drop RegWriteM -> both 1. Set RsE=0 -> ForwardAE=0.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for one cycle and StallCount +1. With RtE=0 -> no stall.
- Multi-cycle RAW: issue with MdLatE=3, WriteRegE=9, then RsD=9 -> stall on the 3 edges after issue, released the next cycle, StallCount=3.
- Structural, NENT=2: issue two ops with latency 4 on consecutive cycles, then MdOpD=1 -> MdFull=1 and stall until the first entry retires.
- Simultaneous retire and issue: entry 0 reaches cnt 1 while MdIssueE=1 with entry 1 free -> entry 1 loads, entry 0 goes idle, MdBusy=2'b10.
- Reset mid-op: rst_n pulled low asynchronously with cnt=5 -> MdBusy=0 immediately and StallCount=0. Saturation: preload to near max with CW=4 -> holds at 15.
